// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle accumulator-CPU controller:
// state encodings, opcode constants and the decode helper.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    FAULT  = 3'd7
  } state_t;

  localparam logic [2:0] OP_LDR = 3'b000;
  localparam logic [2:0] OP_STR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JEZ = 3'b101;
  localparam logic [2:0] OP_SWP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for the memory handshake; expired is high once the
// counter has reached TIMEOUT, and the counter never runs past it.
module mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller: fetch/decode/execute/memory/writeback sequencing with a
// req/ack memory handshake, wait-state timeout, HALT and sticky FAULT states.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                rd_mem,
  output logic                wr_mem,
  output logic                ir_load,
  output logic                enPC,
  output logic                pc_src,
  output logic                ld_r0,
  output logic                r0_src,
  output logic                add,
  output logic                sub,
  output logic                swap_reg,
  output logic                busy,
  output logic                fault,
  output logic [2:0]          state_o
);

  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic [2:0]          op3;
  logic                illegal;
  logic                waiting;
  logic                expired;

  assign op3     = op_q[2:0];
  assign illegal = |(op_q >> 3);
  assign waiting = (state == FETCH) || (state == MEM);

  // Counter is zero on every entry to FETCH/MEM: it is held clear outside the
  // wait states and cleared on the ack cycle (STR goes MEM -> FETCH directly).
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!waiting || mem_ack),
    .en      (waiting && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      case (state)
        IDLE, HALT, FAULT: if (start) state <= FETCH;
        FETCH: begin
          if (mem_ack) begin
            op_q  <= opcode;
            state <= DECODE;
          end else if (expired) begin
            state <= FAULT;
          end
        end
        DECODE: begin
          if (illegal)             state <= FAULT;
          else if (is_mem_op(op3)) state <= MEM;
          else if (op3 == OP_HLT)  state <= HALT;
          else                     state <= EXEC;
        end
        EXEC: state <= FETCH;
        // An ack on the last allowed wait cycle still completes normally.
        MEM: begin
          if (mem_ack)      state <= (op3 == OP_LDR) ? WB : FETCH;
          else if (expired) state <= FAULT;
        end
        WB:      state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    rd_mem   = 1'b0;
    wr_mem   = 1'b0;
    ir_load  = 1'b0;
    enPC     = 1'b0;
    pc_src   = 1'b0;
    ld_r0    = 1'b0;
    r0_src   = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    swap_reg = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        rd_mem  = 1'b1;
        ir_load = mem_ack;
      end
      EXEC: begin
        enPC = 1'b1;
        case (op3)
          OP_ADD: begin add = 1'b1; ld_r0 = 1'b1; end
          OP_SUB: begin sub = 1'b1; ld_r0 = 1'b1; end
          OP_JMP: pc_src = 1'b1;
          OP_JEZ: pc_src = zero;
          OP_SWP: swap_reg = 1'b1;
          default: ;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        rd_mem  = (op3 == OP_LDR);
        wr_mem  = (op3 == OP_STR);
        enPC    = (op3 == OP_STR) && mem_ack;
      end
      WB: begin
        ld_r0  = 1'b1;
        r0_src = 1'b1;
        enPC   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state != IDLE) && (state != HALT) && (state != FAULT);
  assign fault   = (state == FAULT);
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: a vector table walks every instruction on the default
// controller; hand sequences cover timeout, illegal opcode and async reset.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  // Output bit masks, packed {mem_req,rd_mem,wr_mem,ir_load,enPC,pc_src,
  // ld_r0,r0_src,add,sub,swap_reg,busy,fault}.
  localparam logic [12:0] M_REQ  = 13'h1000;
  localparam logic [12:0] M_RD   = 13'h0800;
  localparam logic [12:0] M_WR   = 13'h0400;
  localparam logic [12:0] M_IR   = 13'h0200;
  localparam logic [12:0] M_PC   = 13'h0100;
  localparam logic [12:0] M_PCS  = 13'h0080;
  localparam logic [12:0] M_LD   = 13'h0040;
  localparam logic [12:0] M_R0S  = 13'h0020;
  localparam logic [12:0] M_ADD  = 13'h0010;
  localparam logic [12:0] M_SUB  = 13'h0008;
  localparam logic [12:0] M_SWP  = 13'h0004;
  localparam logic [12:0] M_BUSY = 13'h0002;
  localparam logic [12:0] M_FLT  = 13'h0001;
  localparam logic [12:0] M_NONE = 13'h0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       start, zero, mem_ack;
  logic [2:0] opcode;
  logic mem_req, rd_mem, wr_mem, ir_load, enPC, pc_src, ld_r0, r0_src;
  logic add, sub, swap_reg, busy, fault;
  logic [2:0] state_o;

  // Instance B: 4-bit opcode, short timeout
  logic       start_b, zero_b, mem_ack_b;
  logic [3:0] opcode_b;
  logic mem_req_b, rd_mem_b, wr_mem_b, ir_load_b, enPC_b, pc_src_b, ld_r0_b, r0_src_b;
  logic add_b, sub_b, swap_reg_b, busy_b, fault_b;
  logic [2:0] state_o_b;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .ir_load(ir_load), .enPC(enPC), .pc_src(pc_src), .ld_r0(ld_r0),
    .r0_src(r0_src), .add(add), .sub(sub), .swap_reg(swap_reg), .busy(busy),
    .fault(fault), .state_o(state_o)
  );

  multicycle_controller #(.OPCODE_W(4), .TIMEOUT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .opcode(opcode_b), .zero(zero_b),
    .mem_ack(mem_ack_b), .mem_req(mem_req_b), .rd_mem(rd_mem_b), .wr_mem(wr_mem_b),
    .ir_load(ir_load_b), .enPC(enPC_b), .pc_src(pc_src_b), .ld_r0(ld_r0_b),
    .r0_src(r0_src_b), .add(add_b), .sub(sub_b), .swap_reg(swap_reg_b), .busy(busy_b),
    .fault(fault_b), .state_o(state_o_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       start;
    logic [2:0] op;
    logic       zero;
    logic       ack;
    logic [2:0] st;
    logic [12:0] out;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [12:0] pack_a();
    return {mem_req, rd_mem, wr_mem, ir_load, enPC, pc_src, ld_r0, r0_src,
            add, sub, swap_reg, busy, fault};
  endfunction

  function automatic logic [12:0] pack_b();
    return {mem_req_b, rd_mem_b, wr_mem_b, ir_load_b, enPC_b, pc_src_b, ld_r0_b,
            r0_src_b, add_b, sub_b, swap_reg_b, busy_b, fault_b};
  endfunction

  task automatic check(input string name, input logic [2:0] act_st, input logic [2:0] exp_st,
                       input logic [12:0] act, input logic [12:0] exp_out);
    n_vec++;
    if (act_st !== exp_st || act !== exp_out) begin
      n_bad++;
      $display("FAIL %s: state=%0d outs=%b, expected state=%0d outs=%b",
               name, act_st, act, exp_st, exp_out);
    end
  endtask

  task automatic addv(input logic s, input logic [2:0] op, input logic z, input logic a,
                      input logic [2:0] st, input logic [12:0] out);
    vec_t v;
    v.start = s; v.op = op; v.zero = z; v.ack = a; v.st = st; v.out = out;
    tbl.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs sampled 1 time unit later.
  task automatic step_a(input logic s, input logic [2:0] op, input logic z, input logic a,
                        input logic [2:0] est, input logic [12:0] eout, input string name);
    start = s; opcode = op; zero = z; mem_ack = a;
    #1;
    check(name, state_o, est, pack_a(), eout);
    @(negedge clk);
  endtask

  task automatic step_b(input logic s, input logic [3:0] op, input logic a,
                        input logic [2:0] est, input logic [12:0] eout, input string name);
    start_b = s; opcode_b = op; zero_b = 1'b0; mem_ack_b = a;
    #1;
    check(name, state_o_b, est, pack_b(), eout);
    @(negedge clk);
  endtask

  initial begin
    start = 0; opcode = '0; zero = 0; mem_ack = 0;
    start_b = 0; opcode_b = '0; zero_b = 0; mem_ack_b = 0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("reset_a", state_o, IDLE, pack_a(), M_NONE);
    check("reset_b", state_o_b, IDLE, pack_b(), M_NONE);
    @(negedge clk);
    rst_n = 1'b1;

    // Instance B: ack exactly when the counter reaches TIMEOUT=3 wins
    step_b(1, 4'h0, 0, IDLE,  M_NONE, "b_idle_start");
    for (int i = 0; i < 3; i++)
      step_b(0, 4'h0, 0, FETCH, M_REQ | M_RD | M_BUSY, $sformatf("b_fetch_wait%0d", i));
    step_b(0, 4'b0010, 1, FETCH, M_REQ | M_RD | M_IR | M_BUSY, "b_fetch_ack_at_limit");
    step_b(0, 4'h0, 0, DECODE, M_BUSY, "b_decode_add");
    step_b(0, 4'h0, 0, EXEC, M_PC | M_LD | M_ADD | M_BUSY, "b_exec_add");
    // Illegal opcode with nonzero upper bit
    step_b(0, 4'b1010, 1, FETCH, M_REQ | M_RD | M_IR | M_BUSY, "b_fetch_illegal");
    step_b(0, 4'h0, 0, DECODE, M_BUSY, "b_decode_illegal");
    step_b(1, 4'h0, 0, FAULT, M_FLT, "b_fault_illegal");
    // Timeout: counts 0..3 without ack, then FAULT
    for (int i = 0; i < 4; i++)
      step_b(0, 4'h0, 0, FETCH, M_REQ | M_RD | M_BUSY, $sformatf("b_timeout_wait%0d", i));
    step_b(0, 4'h0, 0, FAULT, M_FLT, "b_fault_timeout");

    // Instance A vector table, starting from IDLE
    addv(0, 3'b000, 0, 0, IDLE,   M_NONE);
    addv(1, 3'b000, 0, 0, IDLE,   M_NONE);
    addv(0, OP_ADD, 0, 1, FETCH,  M_REQ | M_RD | M_IR | M_BUSY);
    addv(0, 3'b000, 0, 0, DECODE, M_BUSY);
    addv(1, 3'b000, 0, 0, EXEC,   M_PC | M_LD | M_ADD | M_BUSY);
    addv(0, 3'b000, 0, 0, FETCH,  M_REQ | M_RD | M_BUSY);
    addv(0, OP_LDR, 0, 1, FETCH,  M_REQ | M_RD | M_IR | M_BUSY);
    addv(0, 3'b000, 0, 0, DECODE, M_BUSY);
    addv(0, 3'b000, 0, 0, MEM,    M_REQ | M_RD | M_BUSY);
    addv(0, 3'b000, 0, 0, MEM,    M_REQ | M_RD | M_BUSY);
    addv(0, 3'b000, 0, 0, MEM,    M_REQ | M_RD | M_BUSY);
    addv(0, 3'b000, 0, 1, MEM,    M_REQ | M_RD | M_BUSY);
    addv(0, 3'b000, 0, 0, WB,     M_LD | M_R0S | M_PC | M_BUSY);
    addv(0, OP_JEZ, 1, 1, FETCH,  M_REQ | M_RD | M_IR | M_BUSY);
    addv(0, 3'b000, 1, 0, DECODE, M_BUSY);
    addv(0, 3'b000, 1, 0, EXEC,   M_PC | M_PCS | M_BUSY);
    addv(0, OP_JEZ, 0, 1, FETCH,  M_REQ | M_RD | M_IR | M_BUSY);
    addv(0, 3'b000, 0, 0, DECODE, M_BUSY);
    addv(0, 3'b000, 0, 0, EXEC,   M_PC | M_BUSY);
    addv(0, OP_SUB, 0, 1, FETCH,  M_REQ | M_RD | M_IR | M_BUSY);
    addv(0, 3'b000, 0, 1, DECODE, M_BUSY);
    addv(0, 3'b000, 0, 0, EXEC,   M_PC | M_LD | M_SUB | M_BUSY);
    addv(0, OP_SWP, 0, 1, FETCH,  M_REQ | M_RD | M_IR | M_BUSY);
    addv(0, 3'b000, 0, 0, DECODE, M_BUSY);
    addv(0, 3'b000, 0, 0, EXEC,   M_PC | M_SWP | M_BUSY);
    addv(0, OP_JMP, 0, 1, FETCH,  M_REQ | M_RD | M_IR | M_BUSY);
    addv(0, 3'b000, 0, 0, DECODE, M_BUSY);
    addv(0, 3'b000, 0, 0, EXEC,   M_PC | M_PCS | M_BUSY);
    addv(0, OP_STR, 0, 1, FETCH,  M_REQ | M_RD | M_IR | M_BUSY);
    addv(0, 3'b000, 0, 0, DECODE, M_BUSY);
    addv(0, 3'b000, 0, 1, MEM,    M_REQ | M_WR | M_PC | M_BUSY);
    addv(0, OP_HLT, 0, 1, FETCH,  M_REQ | M_RD | M_IR | M_BUSY);
    addv(0, 3'b000, 0, 0, DECODE, M_BUSY);
    addv(0, 3'b000, 0, 1, HALT,   M_NONE);
    addv(0, 3'b000, 0, 0, HALT,   M_NONE);
    addv(1, 3'b000, 0, 0, HALT,   M_NONE);

    for (int i = 0; i < tbl.size(); i++)
      step_a(tbl[i].start, tbl[i].op, tbl[i].zero, tbl[i].ack, tbl[i].st, tbl[i].out,
             $sformatf("vec%0d", i));

    // STR with no ack: MEM held for counts 0..15, then FAULT
    step_a(0, OP_STR, 0, 1, FETCH, M_REQ | M_RD | M_IR | M_BUSY, "str_fetch");
    step_a(0, 3'b000, 0, 0, DECODE, M_BUSY, "str_decode");
    for (int i = 0; i < 16; i++)
      step_a(0, 3'b000, 0, 0, MEM, M_REQ | M_WR | M_BUSY, $sformatf("str_wait%0d", i));
    step_a(0, 3'b000, 0, 1, FAULT, M_FLT, "fault_sticky");
    step_a(1, 3'b000, 0, 0, FAULT, M_FLT, "fault_start");
    step_a(0, 3'b000, 0, 0, FETCH, M_REQ | M_RD | M_BUSY, "fault_cleared");

    // Async reset in the middle of a FETCH request, away from the clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", state_o, IDLE, pack_a(), M_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    step_a(0, 3'b000, 0, 1, IDLE, M_NONE, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
